// File: rtl/mem_arb_pkg.sv
// Memory-bus encodings shared by the arbiter and its users: transaction types,
// sizes, ack codes, the non-cacheable address window and the arbiter states.
package mem_arb_pkg;

  localparam logic [1:0] IDLE_ACK      = 2'b00;
  localparam logic [1:0] NORMAL_ACK    = 2'b01;
  localparam logic [1:0] MEM_ERROR_ACK = 2'b10;
  localparam logic [1:0] IO_ERROR_ACK  = 2'b11;

  localparam logic [3:0] ICACHE_LOAD     = 4'b0000;
  localparam logic [3:0] ICACHE_NC_LOAD  = 4'b0010;
  localparam logic [3:0] DCACHE_LOAD     = 4'b0100;
  localparam logic [3:0] WRITE_BACK      = 4'b0101;
  localparam logic [3:0] DCACHE_NC_LOAD  = 4'b0110;
  localparam logic [3:0] DCACHE_NC_STORE = 4'b0111;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_LINE = 2'b11;

  localparam logic [31:0] NC_ADDR_LOW  = 32'h0000_0100;
  localparam logic [31:0] NC_ADDR_HIGH = 32'h000F_FFFF;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_GAP
  } arb_state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last; the last winner is remembered only when take is high.
module mem_arb_rr (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt_vld,
  output logic gnt
);

  logic last_gnt_q;
  logic last_gnt_d;

  always_comb begin
    gnt_vld = req0 | req1;
    gnt     = (req0 && req1) ? ~last_gnt_q : req1;
    last_gnt_d = last_gnt_q;
    if (take && gnt_vld) begin
      last_gnt_d = gnt;
    end
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Shares one memory bus between two ports: one mem_tv per transaction, acks and
// read data steered to the granted port, watchdog-bounded; mem_tv follows req by one cycle.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic        decaf_clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [3:0]  p0_type,
  input  logic [1:0]  p0_size,
  input  logic [31:0] p0_wdata,
  output logic [1:0]  p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p0_done,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [3:0]  p1_type,
  input  logic [1:0]  p1_size,
  input  logic [31:0] p1_wdata,
  output logic [1:0]  p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_done,
  output logic [31:0] mem_addr_bus,
  output logic [3:0]  mem_type,
  output logic [1:0]  mem_size,
  output logic        mem_tv,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  input  logic [1:0]  mem_ack,
  output logic        timeout_err
);

  // Expiry fires on the TIMEOUT_CYCLES-th idle cycle since the last progress.
  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [2:0] beat_count(input logic [3:0] typ, input logic [31:0] addr);
    logic nc;
    nc = (addr >= NC_ADDR_LOW) && (addr <= NC_ADDR_HIGH);
    case (typ)
      ICACHE_LOAD, DCACHE_LOAD:                        beat_count = nc ? 3'd1 : 3'd4;
      WRITE_BACK:                                      beat_count = 3'd4;
      ICACHE_NC_LOAD, DCACHE_NC_LOAD, DCACHE_NC_STORE: beat_count = 3'd1;
      default:                                         beat_count = 3'd0;
    endcase
  endfunction

  arb_state_t      state_q, state_d;
  logic            gnt_q, gnt_d;
  logic [2:0]      beat_cnt_q, beat_cnt_d;
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [3:0]      mem_type_q, mem_type_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic            mem_tv_q, mem_tv_d;
  logic            timeout_err_q, timeout_err_d;

  logic        rr_vld, rr_gnt, take;
  logic        port_sel, done_sel;
  logic [1:0]  ack_sel;
  logic [31:0] sel_addr;
  logic [3:0]  sel_type;
  logic [1:0]  sel_size;
  logic [2:0]  sel_beats;

  mem_arb_rr u_rr (
    .clk     (decaf_clk),
    .reset   (reset),
    .req0    (p0_req),
    .req1    (p1_req),
    .take    (take),
    .gnt_vld (rr_vld),
    .gnt     (rr_gnt)
  );

  always_comb begin
    sel_addr  = rr_gnt ? p1_addr : p0_addr;
    sel_type  = rr_gnt ? p1_type : p0_type;
    sel_size  = rr_gnt ? p1_size : p0_size;
    sel_beats = beat_count(sel_type, sel_addr);

    state_d       = state_q;
    gnt_d         = gnt_q;
    beat_cnt_d    = beat_cnt_q;
    wdog_d        = wdog_q;
    mem_addr_d    = mem_addr_q;
    mem_type_d    = mem_type_q;
    mem_size_d    = mem_size_q;
    mem_tv_d      = 1'b0;
    timeout_err_d = timeout_err_q;
    take          = 1'b0;
    port_sel      = gnt_q;
    ack_sel       = IDLE_ACK;
    done_sel      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        port_sel = rr_gnt;
        if (rr_vld) begin
          take       = 1'b1;
          gnt_d      = rr_gnt;
          mem_addr_d = sel_addr;
          mem_type_d = sel_type;
          mem_size_d = sel_size;
          // Unsupported types never reach the bus; the requester gets an error.
          if (sel_beats == 3'd0) begin
            ack_sel  = MEM_ERROR_ACK;
            done_sel = 1'b1;
            state_d  = ARB_GAP;
          end else begin
            beat_cnt_d = sel_beats;
            mem_tv_d   = 1'b1;
            state_d    = ARB_ISSUE;
          end
        end
      end
      ARB_ISSUE: begin
        wdog_d  = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_ack != IDLE_ACK && beat_cnt_q != 3'd0) begin
          ack_sel = mem_ack;
          wdog_d  = '0;
          if (mem_ack == NORMAL_ACK) begin
            beat_cnt_d = beat_cnt_q - 3'd1;
            if (beat_cnt_q == 3'd1) begin
              done_sel = 1'b1;
              state_d  = ARB_GAP;
            end
          end else begin
            beat_cnt_d = 3'd0;
            done_sel   = 1'b1;
            state_d    = ARB_GAP;
          end
        end else if (wdog_q == WDOG_LAST) begin
          ack_sel       = MEM_ERROR_ACK;
          done_sel      = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = ARB_GAP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ARB_GAP: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge decaf_clk) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      gnt_q         <= 1'b0;
      beat_cnt_q    <= 3'd0;
      wdog_q        <= '0;
      mem_addr_q    <= 32'd0;
      mem_type_q    <= 4'd0;
      mem_size_q    <= 2'd0;
      mem_tv_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      beat_cnt_q    <= beat_cnt_d;
      wdog_q        <= wdog_d;
      mem_addr_q    <= mem_addr_d;
      mem_type_q    <= mem_type_d;
      mem_size_q    <= mem_size_d;
      mem_tv_q      <= mem_tv_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign p0_ack   = port_sel ? IDLE_ACK : ack_sel;
  assign p1_ack   = port_sel ? ack_sel : IDLE_ACK;
  assign p0_done  = ~port_sel & done_sel;
  assign p1_done  = port_sel & done_sel;
  assign p0_rdata = (state_q == ARB_WAIT && !gnt_q) ? mem_data_in : 32'd0;
  assign p1_rdata = (state_q == ARB_WAIT &&  gnt_q) ? mem_data_in : 32'd0;

  assign mem_data_out = gnt_q ? p1_wdata : p0_wdata;
  assign mem_addr_bus = mem_addr_q;
  assign mem_type     = mem_type_q;
  assign mem_size     = mem_size_q;
  assign mem_tv       = mem_tv_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-port arbiter and sequencer that shares the single picoJava-II memory bus (mem_addr_bus/mem_type/mem_size/mem_tv/mem_ack/data) between port 0 (core bus interface) and port 1 (DMA/test loader).
- Issues one mem_tv cycle per transaction and counts the expected acks: 4 beats for cacheable line loads and writebacks, 1 otherwise.
- Steers acks and read data to the granted port only, and bounds every transaction with a watchdog.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles allowed between mem_tv (or the previous ack) and the next non-idle ack.
- TO_W, 9: watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- decaf_clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pN_req  in  1  (N=0,1) request; held high with addr/type/size stable until pN_done.
- pN_addr  in  32  transaction address.
- pN_type  in  4  transaction type, mem.h encoding.
- pN_size  in  2  transfer size, mem.h encoding.
- pN_wdata  in  32  write data for the current beat; requester advances it on each pN_ack != IDLE.
- pN_ack  out  2  ack forwarded to the granted port; IDLE_ACK otherwise.
- pN_rdata  out  32  mem_data_in passed through when granted; 0 otherwise.
- pN_done  out  1  one-cycle pulse on the final ack, error ack, or timeout.
- mem_addr_bus  out  32  registered address to memc.
- mem_type  out  4  registered type.
- mem_size  out  2  registered size.
- mem_tv  out  1  one-cycle transaction-valid pulse.
- mem_data_out  out  32  granted port's pN_wdata, combinational mux.
- mem_data_in  in  32  read data from memc.
- mem_ack  in  2  ack from memc.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset.

Behaviour:
- Reset (synchronous): state=IDLE; mem_tv=0; mem_addr_bus/mem_type/mem_size=0; pN_ack=IDLE_ACK; pN_done=0; timeout_err=0; last_gnt=1, so port 0 wins the first contest.
- Reset asserted mid-transaction aborts it at the next edge. No pN_done is issued; memc drops its own ack under reset.
- States:
  - IDLE: if any req is high, select the winner, latch its addr/type/size into the bus registers, then go to ISSUE.
  - ISSUE: mem_tv=1 for exactly this cycle; load beat_cnt; clear watchdog; go to WAIT.
  - WAIT: count acks, watchdog runs; exits to GAP.
  - GAP: one mandatory idle cycle with mem_tv=0; then IDLE.
- Latency: req sampled high in IDLE gives mem_tv one cycle later. Back-to-back transactions are separated by at least GAP + IDLE, so mem_tv never asserts in consecutive cycles.
- Arbitration:
  - Only one port requesting: grant it.
  - Both requesting: grant !last_gnt (round-robin).
  - last_gnt updates on grant.
  - A request arriving during WAIT waits; no preemption.
- Beat count, decided at latch time:
  - 4 for ICACHE_LOAD or DCACHE_LOAD with addr outside [NC_ADDR_LOW, NC_ADDR_HIGH].
  - 4 for WRITE_BACK.
  - 1 for ICACHE_NC_LOAD, DCACHE_NC_LOAD, DCACHE_NC_STORE, and NC-range loads.
  - Any other type: no mem_tv is issued. Return MEM_ERROR_ACK plus done to the requester on the IDLE→GAP path.
- WAIT ack handling:
  - NORMAL_ACK: decrement beat_cnt; forward ack; restart watchdog. beat_cnt reaching 0 → pN_done=1, go to GAP.
  - MEM_ERROR_ACK or IO_ERROR_ACK: forward it, pN_done=1, go to GAP immediately, whatever beats remain.
  - IDLE_ACK: no count change; watchdog increments.
  - Inter-beat idle gaps of any length up to the timeout are legal.
- Watchdog expiry (count == TIMEOUT_CYCLES):
  - pN_ack=MEM_ERROR_ACK and pN_done=1 for one cycle; timeout_err=1; go to GAP.
  - A late ack arriving in GAP/IDLE is ignored and not forwarded.
- pN_ack and pN_rdata are combinational from mem_ack/mem_data_in, gated by grant and state==WAIT, so data is valid in the same cycle as its ack.
- beat_cnt is 3 bits and never wraps below 0; an ack seen while beat_cnt==0 is ignored.
- pN_req dropping mid-transaction does not abort; the transaction completes on the bus.

Decomposition:
- Constants stay in the shared mem.h: type codes, ack codes, NC_ADDR_LOW/HIGH, size codes. Add a new ARB_IDLE/ISSUE/WAIT/GAP state encoding there, or in a small mem_arb.h.
- One natural sub-module, mem_arb_rr: a 2-way round-robin grant with last_gnt register.
- Beat-count decode stays a function inside mem_arb.

Test Plan:
- Single request: p0 DCACHE_NC_LOAD at 0x0000_1000 (inside NC range), memc acks NORMAL once with data 0xCAFEF00D → mem_tv one cycle; p0_ack NORMAL plus p0_rdata 0xCAFEF00D; p0_done in same cycle; p1_ack stays IDLE.
- Line load: p0 DCACHE_LOAD at 0x0010_0000 (cacheable), 4 NORMAL acks with 3 random idle gaps ≤10 → exactly 4 forwarded acks, done on the 4th, then GAP.
- Contention: p0 and p1 both raise req in the same cycle, each WRITE_BACK → p0 granted first. p1's mem_tv occurs ≥2 cycles after p0_done. mem_data_out equals p1_wdata during p1 beats. A third simultaneous pair grants p0 (alternation).
- Error mid-line: p1 ICACHE_LOAD, memc returns NORMAL then MEM_ERROR_ACK → p1 sees 2 acks, done on the error; no further beats are counted; arbiter returns to IDLE.
- Timeout: TIMEOUT_CYCLES=16, memc never acks → MEM_ERROR_ACK plus done 16 cycles after the last progress; timeout_err=1 and stays high; a late NORMAL_ACK is not forwarded.
- Reset mid-WAIT after 2 of 4 beats → the following cycle has mem_tv=0, all pN_ack IDLE, no done pulse, timeout_err=0, last_gnt=1. A subsequent p0 request proceeds normally.
